// File: rtl/lsq_mem_ctrl_pkg.sv
// Shared types and helpers for the LSQ memory-side responder.
package lsq_mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        DRAIN,
        RESP
    } state_t;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    // Number of memory bytes touched by an access; 0 for the illegal size.
    function automatic logic [2:0] size_to_bytes(input logic [1:0] size);
        case (size)
            SZ_B:    size_to_bytes = 3'd1;
            SZ_H:    size_to_bytes = 3'd2;
            SZ_W:    size_to_bytes = 3'd4;
            default: size_to_bytes = 3'd0;
        endcase
    endfunction

    // Natural alignment check; the illegal size is reported as misaligned.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_B:    is_misaligned = 1'b0;
            SZ_H:    is_misaligned = addr_lo[0];
            SZ_W:    is_misaligned = (addr_lo != 2'b00);
            default: is_misaligned = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsq_mem_ctrl_load_align.sv
// Sign/zero extension of an assembled little-endian load value.
module load_align
    import lsq_mem_ctrl_pkg::*;
(
    input  logic [31:0] assembled,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] result
);

    // Extend from bit 7 or 15 unless unsigned; words pass straight through.
    always_comb begin
        result = assembled;
        case (size)
            SZ_B:    result = {{24{~is_unsigned & assembled[7]}}, assembled[7:0]};
            SZ_H:    result = {{16{~is_unsigned & assembled[15]}}, assembled[15:0]};
            default: result = assembled;
        endcase
    end

endmodule

// File: rtl/lsq_mem_ctrl.sv
// LSQ memory responder: serialises one load/store into byte accesses on an
// 8-bit single-port memory and returns one response per request.
module lsq_mem_ctrl
    import lsq_mem_ctrl_pkg::*;
#(
    parameter int MEM_ADDR_WIDTH = 20,
    parameter int DATA_WIDTH     = 32,
    parameter int TAG_WIDTH      = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_we,
    input  logic [1:0]                req_size,
    input  logic                      req_unsigned,
    input  logic [31:0]               req_addr,
    input  logic [DATA_WIDTH-1:0]     req_wdata,
    input  logic [TAG_WIDTH-1:0]      req_tag,
    output logic                      resp_valid,
    output logic [DATA_WIDTH-1:0]     resp_data,
    output logic [TAG_WIDTH-1:0]      resp_tag,
    output logic                      resp_is_store,
    output logic                      resp_err,
    output logic                      mem_re,
    output logic                      mem_wr,
    output logic [MEM_ADDR_WIDTH-1:0] mem_address,
    output logic [7:0]                mem_wdata,
    input  logic [7:0]                mem_rdata
);

    state_t                    state_reg, state_next;
    logic                      we_reg, unsigned_reg, err_reg;
    logic [1:0]                size_reg, last_reg;
    logic [1:0]                cnt_reg, cnt_next;
    logic [MEM_ADDR_WIDTH-1:0] base_reg;
    logic [DATA_WIDTH-1:0]     wdata_reg;
    logic [TAG_WIDTH-1:0]      tag_reg;
    logic [31:0]               assembled;
    logic [31:0]               load_result;
    logic                      accept;
    logic                      cap_en;
    logic [1:0]                cap_idx;
    logic                      unused_addr_bits;

    // Only the low MEM_ADDR_WIDTH address bits reach the memory.
    assign unused_addr_bits = &{1'b0, req_addr[31:MEM_ADDR_WIDTH]};

    assign accept = req_valid && req_ready;

    // A read byte arrives one cycle after its strobe, so lane cnt-1 is
    // captured while strobe cnt is issued; DRAIN picks up the final lane.
    assign cap_en  = (state_reg == XFER && !we_reg && cnt_reg != 2'd0) || (state_reg == DRAIN);
    assign cap_idx = (state_reg == DRAIN) ? last_reg : cnt_reg - 2'd1;

    // State register; reset aborts any transfer in flight without a response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            cnt_reg   <= 2'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Latch the request fields at the accept edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_reg       <= 1'b0;
            unsigned_reg <= 1'b0;
            err_reg      <= 1'b0;
            size_reg     <= 2'b00;
            last_reg     <= 2'd0;
            base_reg     <= '0;
            wdata_reg    <= '0;
            tag_reg      <= '0;
        end else if (accept) begin
            we_reg       <= req_we;
            unsigned_reg <= req_unsigned;
            err_reg      <= is_misaligned(req_size, req_addr[1:0]);
            size_reg     <= req_size;
            last_reg     <= 2'(size_to_bytes(req_size) - 3'd1);
            base_reg     <= req_addr[MEM_ADDR_WIDTH-1:0];
            wdata_reg    <= req_wdata;
            tag_reg      <= req_tag;
        end
    end

    // One assembly lane per byte of the load result.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_reg;

            // Clear on accept so short loads start from a clean assembly.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    lane_reg <= 8'h00;
                end else if (accept) begin
                    lane_reg <= 8'h00;
                end else if (cap_en && cap_idx == 2'(gi)) begin
                    lane_reg <= mem_rdata;
                end
            end

            assign assembled[8*gi +: 8] = lane_reg;
        end
    endgenerate

    load_align u_load_align (
        .assembled   (assembled),
        .size        (size_reg),
        .is_unsigned (unsigned_reg),
        .result      (load_result)
    );

    // Next-state, byte counter and all outputs, decoded from the current state.
    always_comb begin
        state_next    = state_reg;
        cnt_next      = 2'd0;
        req_ready     = 1'b0;
        mem_re        = 1'b0;
        mem_wr        = 1'b0;
        mem_address   = '0;
        mem_wdata     = 8'h00;
        resp_valid    = 1'b0;
        resp_data     = '0;
        resp_tag      = '0;
        resp_is_store = 1'b0;
        resp_err      = 1'b0;
        case (state_reg)
            IDLE: begin
                req_ready = rst;
                if (accept) begin
                    state_next = is_misaligned(req_size, req_addr[1:0]) ? RESP : XFER;
                end
            end
            XFER: begin
                mem_re      = !we_reg;
                mem_wr      = we_reg;
                mem_address = base_reg + MEM_ADDR_WIDTH'(cnt_reg);
                if (we_reg) begin
                    mem_wdata = wdata_reg[{cnt_reg, 3'b000} +: 8];
                end
                if (cnt_reg == last_reg) begin
                    state_next = we_reg ? RESP : DRAIN;
                end else begin
                    cnt_next = cnt_reg + 2'd1;
                end
            end
            DRAIN: begin
                state_next = RESP;
            end
            RESP: begin
                resp_valid    = 1'b1;
                resp_tag      = tag_reg;
                resp_is_store = we_reg;
                resp_err      = err_reg;
                if (!we_reg && !err_reg) begin
                    resp_data = DATA_WIDTH'(load_result);
                end
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_lsq_mem_ctrl.sv
// Directed bench for lsq_mem_ctrl with a byte-wide memory model.
module tb_lsq_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic [5:0]  req_tag;
    logic        resp_valid, resp_is_store, resp_err;
    logic [31:0] resp_data;
    logic [5:0]  resp_tag;
    logic        mem_re, mem_wr;
    logic [19:0] mem_address;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = 8'h00;

    int tests_run    = 0;
    int tests_failed = 0;
    int resp_count   = 0;
    int both_high    = 0;

    logic        nxt_we, nxt_uns;
    logic [1:0]  nxt_size;
    logic [31:0] nxt_addr, nxt_wdata;
    logic [5:0]  nxt_tag;

    logic [7:0] mem_model [0:4095];

    always #5 clk = ~clk;

    lsq_mem_ctrl #(.MEM_ADDR_WIDTH(20), .DATA_WIDTH(32), .TAG_WIDTH(6)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_we        (req_we),
        .req_size      (req_size),
        .req_unsigned  (req_unsigned),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_tag       (req_tag),
        .resp_valid    (resp_valid),
        .resp_data     (resp_data),
        .resp_tag      (resp_tag),
        .resp_is_store (resp_is_store),
        .resp_err      (resp_err),
        .mem_re        (mem_re),
        .mem_wr        (mem_wr),
        .mem_address   (mem_address),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata)
    );

    // Byte memory: read data appears in the cycle after the strobe.
    always @(posedge clk) begin
        if (mem_wr) mem_model[mem_address[11:0]] <= mem_wdata;
        if (mem_re) mem_rdata <= mem_model[mem_address[11:0]];
    end

    // Count responses and any cycle with both strobes high.
    always @(negedge clk) begin
        if (resp_valid) resp_count++;
        if (mem_re && mem_wr) both_high++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one request and check every cycle up to and just after RESP.
    task automatic run_req(input string name, input logic we, input logic [1:0] size,
                           input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [5:0] tag, input logic [31:0] exp_data,
                           input logic exp_err, input logic hold_next, input logic exp_immediate);
        int n, lat, waits;
        logic [19:0] base;
        logic exp_re, exp_wr;
        n     = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
        lat   = exp_err ? 1 : (we ? n + 1 : n + 2);
        base  = addr[19:0];
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata; req_tag = tag;
        waits = 0;
        while (!req_ready && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        if (!req_ready) begin
            check({name, "_ready_timeout"}, 32'(req_ready), 32'd1);
            req_valid = 1'b0;
            return;
        end
        if (exp_immediate) check({name, "_b2b_wait"}, 32'(waits), 32'd0);
        @(posedge clk);
        #1;
        if (hold_next) begin
            req_we = nxt_we; req_size = nxt_size; req_unsigned = nxt_uns;
            req_addr = nxt_addr; req_wdata = nxt_wdata; req_tag = nxt_tag;
        end else begin
            req_valid = 1'b0;
        end
        for (int k = 1; k <= lat + 1; k++) begin
            @(negedge clk);
            if (k <= lat) begin
                exp_re = !we && !exp_err && (k <= n);
                exp_wr = we && !exp_err && (k <= n);
                check({name, "_busy"}, 32'(req_ready), 32'd0);
                check({name, "_re"}, 32'(mem_re), 32'(exp_re));
                check({name, "_wr"}, 32'(mem_wr), 32'(exp_wr));
                if (exp_re || exp_wr)
                    check({name, "_addr"}, 32'(mem_address), 32'(base + 20'(k - 1)));
                if (exp_wr)
                    check({name, "_wdata"}, 32'(mem_wdata), 32'(wdata[8*(k-1) +: 8]));
                check({name, "_resp_valid"}, 32'(resp_valid), 32'(k == lat));
                if (k == lat) begin
                    check({name, "_tag"}, 32'(resp_tag), 32'(tag));
                    check({name, "_is_store"}, 32'(resp_is_store), 32'(we));
                    check({name, "_err"}, 32'(resp_err), 32'(exp_err));
                    check({name, "_data"}, resp_data, exp_data);
                    $display("[TB] %s: tag=%0d data=0x%08h err=%0b store=%0b", name,
                             resp_tag, resp_data, resp_err, resp_is_store);
                end
            end else begin
                check({name, "_ready_after"}, 32'(req_ready), 32'd1);
                check({name, "_resp_clear"}, 32'(resp_valid), 32'd0);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt_before;
        for (int i = 0; i < 4096; i++) mem_model[i] = 8'h00;
        rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0; req_tag = 6'd0;
        nxt_we = 1'b0; nxt_size = 2'b00; nxt_uns = 1'b0; nxt_addr = 32'h0;
        nxt_wdata = 32'h0; nxt_tag = 6'd0;

        #12;
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_mem_re", 32'(mem_re), 32'd0);
        check("rst_mem_wr", 32'(mem_wr), 32'd0);
        check("rst_mem_addr", 32'(mem_address), 32'd0);
        check("rst_resp_data", resp_data, 32'd0);
        check("rst_resp_tag", 32'(resp_tag), 32'd0);
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'd1);

        run_req("st_w_100", 1'b1, 2'b10, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 6'd5, 32'h0, 1'b0, 1'b0, 1'b0);
        run_req("ld_w_100", 1'b0, 2'b10, 1'b0, 32'hABC0_0100, 32'h0, 6'd6, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
        run_req("ld_b_103s", 1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0, 6'd7, 32'hFFFF_FFDE, 1'b0, 1'b0, 1'b0);
        run_req("ld_b_103u", 1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'h0, 6'd8, 32'h0000_00DE, 1'b0, 1'b0, 1'b0);
        run_req("ld_h_102s", 1'b0, 2'b01, 1'b0, 32'h0000_0102, 32'h0, 6'd9, 32'hFFFF_DEAD, 1'b0, 1'b0, 1'b0);
        run_req("ld_h_101", 1'b0, 2'b01, 1'b0, 32'h0000_0101, 32'h0, 6'd10, 32'h0, 1'b1, 1'b0, 1'b0);
        run_req("ld_sz3", 1'b0, 2'b11, 1'b0, 32'h0000_0100, 32'h0, 6'd11, 32'h0, 1'b1, 1'b0, 1'b0);
        run_req("st_w_102", 1'b1, 2'b10, 1'b0, 32'h0000_0102, 32'h1111_2222, 6'd13, 32'h0, 1'b1, 1'b0, 1'b0);

        // Back-to-back: load held valid while the store is busy.
        nxt_we = 1'b0; nxt_size = 2'b00; nxt_uns = 1'b0; nxt_addr = 32'h0000_0200;
        nxt_wdata = 32'h0; nxt_tag = 6'd21;
        run_req("b2b_st_200", 1'b1, 2'b10, 1'b0, 32'h0000_0200, 32'h1234_5680, 6'd20, 32'h0, 1'b0, 1'b1, 1'b0);
        run_req("b2b_ld_200", 1'b0, 2'b00, 1'b0, 32'h0000_0200, 32'h0, 6'd21, 32'hFFFF_FF80, 1'b0, 1'b0, 1'b1);
        run_req("ld_w_200", 1'b0, 2'b10, 1'b0, 32'h0000_0200, 32'h0, 6'd22, 32'h1234_5680, 1'b0, 1'b0, 1'b0);
        run_req("ld_h_202u", 1'b0, 2'b01, 1'b1, 32'h0000_0202, 32'h0, 6'd23, 32'h0000_1234, 1'b0, 1'b0, 1'b0);
        run_req("st_b_201", 1'b1, 2'b00, 1'b0, 32'h0000_0201, 32'h0000_00AB, 6'd24, 32'h0, 1'b0, 1'b0, 1'b0);
        run_req("ld_b_201u", 1'b0, 2'b00, 1'b1, 32'h0000_0201, 32'h0, 6'd25, 32'h0000_00AB, 1'b0, 1'b0, 1'b0);

        // Reset in the second XFER cycle of a word load.
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'h0000_0100; req_wdata = 32'h0; req_tag = 6'd12;
        check("mid_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1 req_valid = 1'b0;
        @(negedge clk);
        check("mid_re_1", 32'(mem_re), 32'd1);
        @(negedge clk);
        check("mid_re_2", 32'(mem_re), 32'd1);
        check("mid_addr_2", 32'(mem_address), 32'h101);
        cnt_before = resp_count;
        #2 rst = 1'b0;
        #1;
        check("mid_rst_re", 32'(mem_re), 32'd0);
        check("mid_rst_wr", 32'(mem_wr), 32'd0);
        check("mid_rst_addr", 32'(mem_address), 32'd0);
        check("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
        check("mid_rst_resp_tag", 32'(resp_tag), 32'd0);
        check("mid_rst_resp_data", resp_data, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (8) @(negedge clk);
        check("mid_ready_after", 32'(req_ready), 32'd1);
        check("mid_no_resp", 32'(resp_count), 32'(cnt_before));
        $display("[TB] reset_mid_xfer: dropped tag=12");
        run_req("post_rst_ld_b", 1'b0, 2'b00, 1'b0, 32'h0000_0100, 32'h0, 6'd30, 32'hFFFF_FFEF, 1'b0, 1'b0, 1'b0);

        check("strobes_exclusive", 32'(both_high), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
